// File: rtl/hash_seq_ctrl_if.sv
// rtl/hash_seq_ctrl_if.sv - handshake and strobe bundle for the hash sequencer
//
// Purpose: groups the start/busy/done handshake, the hold input and all
// ternary-unit and hash control strobes of hash_seq_ctrl.
// Modports:
//   master - drives start, rounds_cfg, hold; observes every status/strobe
//   slave  - the sequencer side (hash_seq_ctrl)
// Signals:
//   start, rounds_cfg[ROUND_W], hold           : requester -> sequencer
//   busy, done, phase[PHASE_W], p3_rst1/2,
//   step_en, step[STEP_W], round[ROUND_W],
//   hash_rst1/2, hash_sp, hash_ans,
//   hash_keccak, hash_fin, stalled            : sequencer -> requester
interface hash_seq_ctrl_if #(
   parameter int STEP_W  = 8,
   parameter int ROUND_W = 2,
   parameter int PHASE_W = 3
) ();
   logic               start;
   logic [ROUND_W-1:0] rounds_cfg;
   logic               hold;
   logic               busy;
   logic               done;
   logic [PHASE_W-1:0] phase;
   logic               p3_rst1;
   logic               p3_rst2;
   logic               step_en;
   logic [STEP_W-1:0]  step;
   logic [ROUND_W-1:0] round;
   logic               hash_rst1;
   logic               hash_rst2;
   logic               hash_sp;
   logic               hash_ans;
   logic               hash_keccak;
   logic               hash_fin;
   logic               stalled;

   modport master (
      output start, rounds_cfg, hold,
      input  busy, done, phase, p3_rst1, p3_rst2, step_en, step, round,
             hash_rst1, hash_rst2, hash_sp, hash_ans, hash_keccak, hash_fin, stalled
   );

   modport slave (
      input  start, rounds_cfg, hold,
      output busy, done, phase, p3_rst1, p3_rst2, step_en, step, round,
             hash_rst1, hash_rst2, hash_sp, hash_ans, hash_keccak, hash_fin, stalled
   );
endinterface

// File: rtl/hash_seq_ctrl.sv
// rtl/hash_seq_ctrl.sv - phase/step sequencer for the ternary-add and hash datapath
//
// Purpose: a free-running phase prescaler produces a one-cycle step_en strobe
// once per PHASES cycles; while running, each step_en advances a step index
// through 0..STEP_LAST and counts completed rounds at ANS_STEP. Ternary-unit
// (p3_*) and hash (hash_*) strobes are decoded from the registered state.
// Ports:
//   clk      - system clock, all state on the rising edge
//   ovr_rst1 - synchronous active-high reset, wins over every other input
//   bus      - hash_seq_ctrl_if slave: start/rounds_cfg/hold in, status and
//              strobes out
module hash_seq_ctrl #(
   parameter int PHASES     = 5,
   parameter int STEP_PHASE = 2,
   parameter int STEP_W     = 8,
   parameter int STEP_LAST  = 68,
   parameter int SP_FIRST   = 1,
   parameter int SP_LAST    = 2,
   parameter int RST2_STEP  = 4,
   parameter int ANS_STEP   = 30,
   parameter int ROUNDS     = 3,
   parameter int ROUND_W    = 2
) (
   input  logic            clk,
   input  logic            ovr_rst1,
   hash_seq_ctrl_if.slave  bus
);
   localparam int PHASE_W = (PHASES > 1) ? $clog2(PHASES) : 1;

   localparam logic [PHASE_W-1:0] PHASE_LAST  = PHASE_W'(PHASES - 1);
   localparam logic [PHASE_W-1:0] PHASE_STEP  = PHASE_W'(STEP_PHASE);
   localparam logic [PHASE_W-1:0] PHASE_ONE   = PHASE_W'(1);
   localparam logic [PHASE_W-1:0] PHASE_TWO   = PHASE_W'(2);
   localparam logic [STEP_W-1:0]  STEP_ONE    = STEP_W'(1);
   localparam logic [STEP_W-1:0]  STEP_END    = STEP_W'(STEP_LAST);
   localparam logic [STEP_W-1:0]  STEP_ANS    = STEP_W'(ANS_STEP);
   localparam logic [STEP_W-1:0]  STEP_RST2   = STEP_W'(RST2_STEP);
   localparam logic [STEP_W-1:0]  STEP_SP_LO  = STEP_W'(SP_FIRST);
   localparam logic [STEP_W-1:0]  STEP_SP_HI  = STEP_W'(SP_LAST);
   localparam logic [ROUND_W-1:0] ROUND_ONE   = ROUND_W'(1);
   localparam logic [ROUND_W-1:0] ROUND_DFLT  = ROUND_W'(ROUNDS);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [PHASE_W-1:0]   phase_q, phase_d;
   logic [STEP_W-1:0]    step_q,  step_d;
   logic [ROUND_W-1:0]   round_q, round_d;
   logic [ROUND_W-1:0]   target_q, target_d;
   logic                 run;
   logic                 step_en;

   always_ff @(posedge clk) begin
      if (ovr_rst1) begin
         state_q  <= ST_IDLE;
         phase_q  <= '0;
         step_q   <= '0;
         round_q  <= '0;
         target_q <= '0;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         step_q   <= step_d;
         round_q  <= round_d;
         target_q <= target_d;
      end
   end

   assign run     = (state_q == ST_RUN);
   // hold only gates the step strobe; the prescaler keeps running so a
   // released hold resumes on the next STEP_PHASE slot.
   assign step_en = run && (phase_q == PHASE_STEP) && !bus.hold;

   always_comb begin
      state_d  = state_q;
      step_d   = step_q;
      round_d  = round_q;
      target_d = target_q;
      phase_d  = (phase_q == PHASE_LAST) ? '0 : phase_q + PHASE_ONE;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               target_d = (bus.rounds_cfg == '0) ? ROUND_DFLT : bus.rounds_cfg;
               step_d   = '0;
               round_d  = '0;
               state_d  = ST_RUN;
            end
         end
         ST_RUN: begin
            if (step_en) begin
               // target is never 0 in RUN, so target_q - 1 cannot underflow.
               if ((step_q == STEP_ANS) && (round_q == (target_q - ROUND_ONE))) begin
                  round_d = target_q;
                  step_d  = '0;
                  state_d = ST_DONE;
               end else if (step_q == STEP_ANS) begin
                  round_d = round_q + ROUND_ONE;
                  step_d  = step_q + STEP_ONE;
               end else if (step_q == STEP_END) begin
                  step_d  = '0;
               end else begin
                  step_d  = step_q + STEP_ONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign bus.busy        = run;
   assign bus.done        = (state_q == ST_DONE);
   assign bus.phase       = phase_q;
   assign bus.p3_rst1     = (phase_q == PHASE_ONE);
   assign bus.p3_rst2     = (phase_q == PHASE_TWO);
   assign bus.step_en     = step_en;
   assign bus.step        = step_q;
   assign bus.round       = round_q;
   assign bus.hash_rst1   = run && (step_q == '0) && (round_q == '0);
   assign bus.hash_rst2   = run && (step_q == STEP_RST2);
   assign bus.hash_sp     = run && (step_q >= STEP_SP_LO) && (step_q <= STEP_SP_HI);
   assign bus.hash_ans    = run && (step_q == STEP_ANS);
   assign bus.hash_keccak = run && step_q[0];
   // target is 0 only after reset, which keeps hash_fin low until a sequence
   // has actually completed; it then holds until the next accepted start.
   assign bus.hash_fin    = (target_q != '0) && (round_q == target_q);
   assign bus.stalled     = run && bus.hold;
endmodule

// File: tb/tb_hash_seq_ctrl.sv
// tb/tb_hash_seq_ctrl.sv - self-checking bench for hash_seq_ctrl
module tb_hash_seq_ctrl;
   localparam int PHASES     = 5;
   localparam int STEP_PHASE = 2;
   localparam int STEP_LAST  = 68;
   localparam int SP_FIRST   = 1;
   localparam int SP_LAST    = 2;
   localparam int RST2_STEP  = 4;
   localparam int ANS_STEP   = 30;
   localparam int ROUNDS     = 3;
   localparam int PASS_LEN   = STEP_LAST + 1;
   localparam int ANS_LEN    = ANS_STEP + 1;

   logic clk = 1'b0;
   logic ovr_rst1 = 1'b1;

   hash_seq_ctrl_if #(.STEP_W(8), .ROUND_W(2), .PHASE_W(3)) bus ();

   hash_seq_ctrl dut (
      .clk      (clk),
      .ovr_rst1 (ovr_rst1),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;
   int pulses   = 0;
   int anses    = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model: a sequence is tracked as the number of step pulses taken so far;
   // step/round follow arithmetically from that count and the round target.
   int m_cyc  = 0;
   int m_mode = 0;   // 0 idle, 1 running, 2 completion cycle
   int m_k    = 0;
   int m_t    = 0;
   bit m_fin  = 1'b0;

   always @(posedge clk) begin
      automatic bit en;
      en = (m_mode == 1) && ((m_cyc % PHASES) == STEP_PHASE) && !bus.hold;
      if (ovr_rst1) begin
         m_cyc = 0; m_mode = 0; m_k = 0; m_t = 0; m_fin = 1'b0;
      end else begin
         m_cyc++;
         if (m_mode == 2) begin
            m_mode = 0;
         end else if (m_mode == 0) begin
            if (bus.start) begin
               m_mode = 1;
               m_k    = 0;
               m_t    = (bus.rounds_cfg == 0) ? ROUNDS : int'(bus.rounds_cfg);
               m_fin  = 1'b0;
            end
         end else if (en) begin
            m_k++;
            if (m_k == ANS_LEN + (m_t - 1) * PASS_LEN) begin
               m_mode = 2;
               m_fin  = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      automatic bit run;
      automatic int e_step, e_round, e_phase;
      if (chk_en) begin
         run     = (m_mode == 1);
         e_phase = m_cyc % PHASES;
         e_step  = run ? (m_k % PASS_LEN) : 0;
         if (run)        e_round = (m_k < ANS_LEN) ? 0 : (m_k - ANS_LEN) / PASS_LEN + 1;
         else if (m_fin) e_round = m_t;
         else            e_round = 0;
         chk("phase",       int'(bus.phase),       e_phase);
         chk("p3_rst1",     int'(bus.p3_rst1),     int'(e_phase == 1));
         chk("p3_rst2",     int'(bus.p3_rst2),     int'(e_phase == 2));
         chk("busy",        int'(bus.busy),        int'(run));
         chk("done",        int'(bus.done),        int'(m_mode == 2));
         chk("step",        int'(bus.step),        e_step);
         chk("round",       int'(bus.round),       e_round);
         chk("step_en",     int'(bus.step_en),     int'(run && e_phase == STEP_PHASE && !bus.hold));
         chk("stalled",     int'(bus.stalled),     int'(run && bus.hold));
         chk("hash_rst1",   int'(bus.hash_rst1),   int'(run && e_step == 0 && e_round == 0));
         chk("hash_rst2",   int'(bus.hash_rst2),   int'(run && e_step == RST2_STEP));
         chk("hash_sp",     int'(bus.hash_sp),     int'(run && e_step >= SP_FIRST && e_step <= SP_LAST));
         chk("hash_ans",    int'(bus.hash_ans),    int'(run && e_step == ANS_STEP));
         chk("hash_keccak", int'(bus.hash_keccak), int'(run && (e_step % 2) == 1));
         chk("hash_fin",    int'(bus.hash_fin),    int'(m_fin));
      end
      if (bus.step_en === 1'b1) begin
         pulses++;
         if (bus.hash_ans === 1'b1) anses++;
      end
   end

   task automatic run_seq(input int cfg, input int exp_pulses, input int exp_rounds,
                          input int hold_at, input int ign_at);
      bit seen;
      bit hold_done;
      bit ign_done;
      seen = 1'b0; hold_done = 1'b0; ign_done = 1'b0;
      pulses = 0; anses = 0;
      bus.rounds_cfg = 2'(cfg);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("start_busy", int'(bus.busy), 1);
      chk("start_fin_clear", int'(bus.hash_fin), 0);
      for (int c = 0; c < 3000 && !seen; c++) begin
         if (hold_at >= 0 && !hold_done && bus.busy && int'(bus.step) == hold_at) begin
            bus.hold = 1'b1;
            for (int h = 0; h < 12; h++) begin
               tick();
               chk("hold_step", int'(bus.step), hold_at);
               chk("hold_stalled", int'(bus.stalled), 1);
               chk("hold_no_step_en", int'(bus.step_en), 0);
            end
            bus.hold = 1'b0;
            hold_done = 1'b1;
         end
         if (ign_at >= 0 && !ign_done && bus.busy && int'(bus.step) == ign_at) begin
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            ign_done = 1'b1;
            chk("start_in_run_busy", int'(bus.busy), 1);
         end
         tick();
         if (bus.done) seen = 1'b1;
      end
      chk("done_seen", int'(seen), 1);
      chk("pulse_count", pulses, exp_pulses);
      chk("ans_count", anses, exp_rounds);
      chk("final_round", int'(bus.round), exp_rounds);
      chk("final_step", int'(bus.step), 0);
      chk("final_fin", int'(bus.hash_fin), 1);
      chk("final_busy", int'(bus.busy), 0);
      tick();
      chk("done_single", int'(bus.done), 0);
      chk("fin_held", int'(bus.hash_fin), 1);
      chk("round_held", int'(bus.round), exp_rounds);
   endtask

   initial begin
      int ph_exp [6];
      bit found;
      ph_exp = '{0, 1, 2, 3, 4, 0};
      bus.start = 1'b0;
      bus.rounds_cfg = 2'd0;
      bus.hold = 1'b0;
      ovr_rst1 = 1'b1;
      repeat (3) tick();
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_step", int'(bus.step), 0);
      chk("rst_round", int'(bus.round), 0);
      chk("rst_phase", int'(bus.phase), 0);
      chk("rst_fin", int'(bus.hash_fin), 0);
      chk("rst_hash_rst1", int'(bus.hash_rst1), 0);
      chk("rst_p3_rst1", int'(bus.p3_rst1), 0);
      ovr_rst1 = 1'b0;
      chk_en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) tick();
         chk("phase_seq", int'(bus.phase), ph_exp[i]);
      end

      // default three-round run, then a start on the cycle after done
      run_seq(0, 169, 3, -1, -1);
      // single round with a start pulse that must be ignored mid-run
      run_seq(1, 31, 1, -1, 5);
      // hold for 12 cycles at step 10
      run_seq(0, 169, 3, 10, -1);
      // two rounds: 31 + 69
      run_seq(2, 100, 2, -1, -1);

      // mid-run reset at step 40 of round 1
      bus.rounds_cfg = 2'd0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 2000 && !found; c++) begin
         if (int'(bus.step) == 40 && int'(bus.round) == 1) found = 1'b1;
         else tick();
      end
      chk("reach_step40", int'(found), 1);
      ovr_rst1 = 1'b1;
      tick();
      ovr_rst1 = 1'b0;
      chk("midrst_busy", int'(bus.busy), 0);
      chk("midrst_step", int'(bus.step), 0);
      chk("midrst_round", int'(bus.round), 0);
      chk("midrst_phase", int'(bus.phase), 0);
      chk("midrst_fin", int'(bus.hash_fin), 0);
      run_seq(0, 169, 3, -1, -1);

      // start coincident with reset stays idle
      ovr_rst1 = 1'b1;
      bus.start = 1'b1;
      tick();
      ovr_rst1 = 1'b0;
      bus.start = 1'b0;
      chk("rst_start_busy", int'(bus.busy), 0);
      tick();
      chk("rst_start_idle", int'(bus.busy), 0);
      chk("rst_start_fin", int'(bus.hash_fin), 0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/hash_seq_ctrl.md
Name: hash_seq_ctrl

Overview:
Parametrised sequencer for the encaps ternary-add / hash datapath. It generates the per-phase ternary-unit strobes (p3_*) and the step-indexed SHA-3/Keccak control strobes (hash_*) over a configurable number of hash rounds. It adds a start/busy/done handshake and an external hold. Single synchronous clock domain: derived clocks are replaced by a one-cycle step_en strobe.

Parameters:
PHASES, 5, prescaler length, cycles per step, >=3
STEP_PHASE, 2, phase index at which step_en fires, <PHASES
STEP_W, 8, step counter width
STEP_LAST, 68, last step of a pass; the step after it wraps to 0
SP_FIRST, 1, first step with hash_sp high
SP_LAST, 2, last step with hash_sp high
RST2_STEP, 4, step with hash_rst2 high
ANS_STEP, 30, answer step; the round completes here; SP_LAST<ANS_STEP<STEP_LAST
ROUNDS, 3, default round count when rounds_cfg==0
ROUND_W, 2, round counter and rounds_cfg width

Ports:
clk  input  1  system clock, all state on rising edge
ovr_rst1  input  1  synchronous active-high reset
start  input  1  begin a sequence; sampled only in IDLE
rounds_cfg  input  ROUND_W  round target; 0 selects ROUNDS
hold  input  1  stall step advance while RUN
busy  output  1  high in RUN
done  output  1  one-cycle pulse on sequence completion
phase  output  clog2(PHASES)  free-running prescaler value
p3_rst1  output  1  phase==1
p3_rst2  output  1  phase==2
step_en  output  1  one-cycle step strobe
step  output  STEP_W  current step index
round  output  ROUND_W  completed rounds
hash_rst1  output  1  RUN & step==0 & round==0
hash_rst2  output  1  RUN & step==RST2_STEP
hash_sp  output  1  RUN & SP_FIRST<=step<=SP_LAST
hash_ans  output  1  RUN & step==ANS_STEP
hash_keccak  output  1  RUN & step[0]
hash_fin  output  1  round==target, held until next start or reset
stalled  output  1  RUN & hold

Behaviour:
- Reset, ovr_rst1 high at an edge: state=IDLE; phase, step, round and target all 0. All outputs are 0 on the next cycle. Reset wins over every other input, including during RUN.
- Phase counter: free-running in every state. Sequence is 0..PHASES-1, then 0. p3_rst1/p3_rst2 are decoded from the registered phase.
- FSM states: IDLE, RUN, DONE.
- IDLE with start=1: target <= (rounds_cfg==0 ? ROUNDS : rounds_cfg); step <= 0; round <= 0; state -> RUN. busy rises the next cycle.
- step_en = RUN & phase==STEP_PHASE & ~hold. It is combinational from registered state.
- Step advance on step_en:
  - If step==ANS_STEP and round==target-1: round <= target, step <= 0, state -> DONE.
  - Else if step==ANS_STEP: round <= round+1, step <= step+1.
  - Else if step==STEP_LAST: step <= 0, round unchanged.
  - Else: step <= step+1.
- hold in RUN: step and round freeze; phase keeps running; stalled=1. Released hold resumes at the next phase==STEP_PHASE.
- DONE: lasts one cycle. done=1, busy=0, then state -> IDLE. round and hash_fin keep their values until the next accepted start.
- start while RUN or DONE: ignored, not queued. start together with ovr_rst1: reset taken, stays IDLE.
- hash_* strobes (except hash_fin) are 0 outside RUN.
- All outputs are decoded from registers, so no combinational path from start/rounds_cfg to any output. The one exception is stalled/step_en depending on hold.
- Pulse count per sequence with target T: ANS_STEP+1 + (T-1)*(STEP_LAST+1) step_en pulses. Defaults give 31+2*69=169.

Test Plan:
- Reset: hold ovr_rst1 3 cycles -> busy=done=step=round=phase=0, all hash_*/p3_* 0; phase then counts 0,1,2,3,4,0.
- Default run: rounds_cfg=0, pulse start -> step_en every 5 cycles at phase==2. hash_sp at steps 1,2; hash_rst2 at 4; hash_rst1 only at step 0 of round 0. hash_ans at step 30 three times. round goes 1,2,3; step wraps 68->0 twice. Exactly 169 step_en pulses, then a single-cycle done; hash_fin=1, round=3.
- Single round: rounds_cfg=1 -> done after 31 step_en pulses, step=0, round=1, hash_fin=1, no wrap observed.
- Hold: assert hold for 12 cycles at step 10 -> step stays 10, stalled=1, no step_en, phase keeps counting. After release, total step_en count still 169.
- Mid-run reset: ovr_rst1 at step 40, round 1 -> next cycle busy=0, step=0, round=0, phase=0, hash_fin=0; a following start runs a full 169-step sequence.
- Handshake edges: start during RUN -> no effect on step/round; start coincident with ovr_rst1 -> remains IDLE; start on the cycle after done -> new run accepted, hash_fin cleared.
